// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue slice.
// Holds the widths that the rest of the fetch path agrees on:
//   INST_CATCH_DEPTH : pc / instruction ROM address width
//   INST_W_DEF       : instruction word width
package inst_fetch_queue_pkg;

  localparam int unsigned INST_CATCH_DEPTH = 10;
  localparam int unsigned INST_W_DEF       = 32;

  // Pointer width for a power-of-two queue depth.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_fetch_fifo_ram.sv
// fetch_fifo_ram: DEPTH x DW register array backing the fetch queue.
// Ports:
//   clk   in          clock
//   we    in          write enable
//   waddr in  [PW]    write index
//   wdata in  [DW]    write data ({pc, inst})
//   raddr in  [PW]    read index
//   rdata out [DW]    asynchronous read data at raddr
module fetch_fifo_ram
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 42,
  parameter int unsigned PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Storage only; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: issues pc to the synchronous instruction ROM, captures
// the returned word one cycle later and buffers {pc, inst} pairs for decode.
// Ports:
//   clk         in            clock
//   rst         in            synchronous active-high reset
//   pc_i        in  [ADDR_W]  current pc from the PC generator
//   jump_flag   in            redirect: flush queued and in-flight fetches
//   hold_o      out           stall to the PC generator
//   rom_addr_o  out [ADDR_W]  ROM read address (pass-through of pc_i)
//   rom_data_i  in  [INST_W]  ROM data, valid the cycle after rom_addr_o
//   out_valid_o out           head entry valid
//   out_ready_i in            decode accepts head entry
//   out_pc_o    out [ADDR_W]  pc of head entry
//   out_inst_o  out [INST_W]  instruction of head entry
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_CATCH_DEPTH,
  parameter int unsigned INST_W = INST_W_DEF,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jump_flag,
  output logic              hold_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic [INST_W-1:0] out_inst_o
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              pop;
  logic              push;
  logic              issue;
  logic [CW:0]       occupancy;

  assign rom_addr_o  = pc_i;
  assign out_valid_o = (count != '0) & ~jump_flag;
  assign pop         = out_valid_o & out_ready_i;

  // Slots committed for the next cycle: queued + returning word - leaving
  // entry. Holding once this reaches DEPTH means a push never finds the
  // FIFO full, so no separate full check is needed on the write side.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
  assign hold_o    = occupancy >= (CW+1)'(DEPTH);

  assign issue = ~hold_o & ~jump_flag & ~rst;
  assign push  = inflight_q & ~jump_flag & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      inflight_q <= 1'b0;
    end else if (jump_flag) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // pc of the word the ROM returns next cycle; only meaningful with inflight_q.
  always_ff @(posedge clk) begin
    if (issue) inflight_pc_q <= pc_i;
  end

  fetch_fifo_ram #(
    .DEPTH (DEPTH),
    .DW    (ADDR_W + INST_W),
    .PW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({inflight_pc_q, rom_data_i}),
    .raddr (rd_ptr),
    .rdata ({out_pc_o, out_inst_o})
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int unsigned AW    = INST_CATCH_DEPTH;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [IW-1:0] TAG = 32'h1000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          jump_flag = 1'b0;
  logic [AW-1:0] jump_addr = '0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] pc;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_data;
  logic          hold;
  logic          out_valid;
  logic [AW-1:0] out_pc;
  logic [IW-1:0] out_inst;

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] sb [$];

  logic          o_valid, o_hold, popped, have_exp;
  logic [AW-1:0] o_pc, o_rom, exp_pc;
  logic [IW-1:0] o_inst;

  always #5 clk = ~clk;

  inst_fetch_queue #(
    .ADDR_W (AW),
    .INST_W (IW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_i        (pc),
    .jump_flag   (jump_flag),
    .hold_o      (hold),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_pc_o    (out_pc),
    .out_inst_o  (out_inst)
  );

  // PC generator: reset to 0, redirect on jump, advance by 4 unless held.
  always @(posedge clk) begin
    if (rst)            pc <= '0;
    else if (jump_flag) pc <= jump_addr;
    else if (!hold)     pc <= pc + AW'(4);
  end

  // Synchronous ROM: one cycle read latency.
  always @(posedge clk) rom_data <= TAG | IW'(rom_addr);

  // One clock of stimulus; samples outputs mid-cycle and updates the
  // scoreboard (pop expected head on handshake, push issued pc, flush on
  // jump/reset).
  task automatic drive_cycle(input logic r, input logic j, input logic [AW-1:0] ja,
                             input logic rdy);
    @(negedge clk);
    rst = r; jump_flag = j; jump_addr = ja; out_ready = rdy;
    #1;
    o_valid = out_valid; o_hold = hold; o_pc = out_pc; o_inst = out_inst;
    o_rom = rom_addr;
    popped = o_valid & rdy;
    have_exp = 1'b0;
    if (popped && sb.size() > 0) begin
      exp_pc = sb.pop_front();
      have_exp = 1'b1;
    end
    if (r || j) sb.delete();
    else if (!o_hold) sb.push_back(pc);
  endtask

  task automatic do_reset();
    repeat (3) drive_cycle(1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", o_valid); end
    n_vec++;
    if (o_hold !== 1'b0) begin n_err++; $display("FAIL reset_hold got %b exp 0", o_hold); end
    drive_cycle(1'b0, 1'b0, '0, 1'b0);
    n_vec++;
    if (o_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid got %b exp 0", o_valid); end
    n_vec++;
    if (o_hold !== 1'b0) begin n_err++; $display("FAIL post_reset_hold got %b exp 0", o_hold); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive_cycle(1'b0, 1'b0, '0, 1'b1);
      n_vec++;
      if (o_rom !== pc) begin n_err++; $display("FAIL stream_rom_addr k=%0d got %h exp %h", k, o_rom, pc); end
      n_vec++;
      if (o_hold !== 1'b0) begin n_err++; $display("FAIL stream_hold k=%0d got %b exp 0", k, o_hold); end
      n_vec++;
      if (o_valid !== (k >= 2)) begin n_err++; $display("FAIL stream_valid k=%0d got %b exp %b", k, o_valid, k >= 2); end
      if (k >= 2) begin
        n_vec++;
        if (o_pc !== AW'((k-2)*4)) begin n_err++; $display("FAIL stream_pc k=%0d got %h exp %h", k, o_pc, AW'((k-2)*4)); end
        n_vec++;
        if (o_inst !== (TAG | IW'((k-2)*4))) begin n_err++; $display("FAIL stream_inst k=%0d got %h exp %h", k, o_inst, TAG | IW'((k-2)*4)); end
      end
      if (popped) begin
        n_vec++;
        if (!have_exp) begin n_err++; $display("FAIL stream_sb_extra k=%0d got pc %h exp none", k, o_pc); end
        else if (o_pc !== exp_pc) begin n_err++; $display("FAIL stream_sb_pc k=%0d got %h exp %h", k, o_pc, exp_pc); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive_cycle(1'b0, 1'b0, '0, 1'b0);
      n_vec++;
      if (o_hold !== (k >= 4)) begin n_err++; $display("FAIL bp_hold k=%0d got %b exp %b", k, o_hold, k >= 4); end
      n_vec++;
      if (o_valid !== (k >= 2)) begin n_err++; $display("FAIL bp_valid k=%0d got %b exp %b", k, o_valid, k >= 2); end
      if (k >= 2) begin
        n_vec++;
        if (o_pc !== '0) begin n_err++; $display("FAIL bp_head_pc k=%0d got %h exp 000", k, o_pc); end
      end
    end
    n_vec++;
    if (sb.size() != DEPTH) begin n_err++; $display("FAIL bp_outstanding got %0d exp %0d", sb.size(), DEPTH); end
    for (int k = 8; k < 16; k++) begin
      drive_cycle(1'b0, 1'b0, '0, 1'b1);
      n_vec++;
      if (o_hold !== 1'b0) begin n_err++; $display("FAIL drain_hold k=%0d got %b exp 0", k, o_hold); end
      n_vec++;
      if (o_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid k=%0d got %b exp 1", k, o_valid); end
      n_vec++;
      if (o_pc !== AW'((k-8)*4)) begin n_err++; $display("FAIL drain_pc k=%0d got %h exp %h", k, o_pc, AW'((k-8)*4)); end
      if (popped) begin
        n_vec++;
        if (!have_exp) begin n_err++; $display("FAIL drain_sb_extra k=%0d got pc %h exp none", k, o_pc); end
        else if (o_inst !== (TAG | IW'(exp_pc))) begin n_err++; $display("FAIL drain_sb_inst k=%0d got %h exp %h", k, o_inst, TAG | IW'(exp_pc)); end
      end
    end
  endtask

  task automatic test_jump_flush();
    do_reset();
    for (int k = 0; k < 4; k++) drive_cycle(1'b0, 1'b0, '0, 1'b0);
    n_vec++;
    if (o_hold !== 1'b0) begin n_err++; $display("FAIL jf_prehold got %b exp 0", o_hold); end
    drive_cycle(1'b0, 1'b1, AW'('h40), 1'b1);
    n_vec++;
    if (o_valid !== 1'b0) begin n_err++; $display("FAIL jf_valid_jump got %b exp 0", o_valid); end
    drive_cycle(1'b0, 1'b0, '0, 1'b1);
    n_vec++;
    if (o_valid !== 1'b0) begin n_err++; $display("FAIL jf_valid_next got %b exp 0", o_valid); end
    n_vec++;
    if (o_hold !== 1'b0) begin n_err++; $display("FAIL jf_hold_next got %b exp 0", o_hold); end
    n_vec++;
    if (o_rom !== AW'('h40)) begin n_err++; $display("FAIL jf_rom_addr got %h exp 040", o_rom); end
    drive_cycle(1'b0, 1'b0, '0, 1'b1);
    n_vec++;
    if (o_valid !== 1'b0) begin n_err++; $display("FAIL jf_valid_gap got %b exp 0", o_valid); end
    for (int k = 7; k < 11; k++) begin
      drive_cycle(1'b0, 1'b0, '0, 1'b1);
      n_vec++;
      if (o_valid !== 1'b1) begin n_err++; $display("FAIL jf_valid k=%0d got %b exp 1", k, o_valid); end
      n_vec++;
      if (o_pc !== AW'('h40 + (k-7)*4)) begin n_err++; $display("FAIL jf_pc k=%0d got %h exp %h", k, o_pc, AW'('h40 + (k-7)*4)); end
      n_vec++;
      if (o_inst !== (TAG | IW'('h40 + (k-7)*4))) begin n_err++; $display("FAIL jf_inst k=%0d got %h exp %h", k, o_inst, TAG | IW'('h40 + (k-7)*4)); end
    end
  endtask

  task automatic test_jump_pop();
    do_reset();
    for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b0, '0, 1'b0);
    drive_cycle(1'b0, 1'b1, AW'('h80), 1'b1);
    n_vec++;
    if (o_valid !== 1'b0) begin n_err++; $display("FAIL jp_valid_jump got %b exp 0", o_valid); end
    drive_cycle(1'b0, 1'b0, '0, 1'b1);
    n_vec++;
    if (o_valid !== 1'b0) begin n_err++; $display("FAIL jp_valid_next got %b exp 0", o_valid); end
    n_vec++;
    if (o_hold !== 1'b0) begin n_err++; $display("FAIL jp_hold_next got %b exp 0", o_hold); end
    drive_cycle(1'b0, 1'b0, '0, 1'b1);
    n_vec++;
    if (o_valid !== 1'b0) begin n_err++; $display("FAIL jp_valid_gap got %b exp 0", o_valid); end
    for (int k = 6; k < 12; k++) begin
      drive_cycle(1'b0, 1'b0, '0, 1'b1);
      n_vec++;
      if (o_pc !== AW'('h80 + (k-6)*4) || o_valid !== 1'b1) begin
        n_err++; $display("FAIL jp_pc k=%0d got %h/v%b exp %h/v1", k, o_pc, o_valid, AW'('h80 + (k-6)*4));
      end
      if (popped) begin
        n_vec++;
        if (!have_exp || o_pc !== exp_pc) begin n_err++; $display("FAIL jp_sb k=%0d got %h exp %h", k, o_pc, exp_pc); end
      end
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b0, '0, 1'b0);
    drive_cycle(1'b1, 1'b0, '0, 1'b1);
    drive_cycle(1'b0, 1'b0, '0, 1'b1);
    n_vec++;
    if (o_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid got %b exp 0", o_valid); end
    n_vec++;
    if (o_hold !== 1'b0) begin n_err++; $display("FAIL rm_hold got %b exp 0", o_hold); end
    drive_cycle(1'b0, 1'b0, '0, 1'b1);
    n_vec++;
    if (o_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid_gap got %b exp 0", o_valid); end
    for (int k = 6; k < 10; k++) begin
      drive_cycle(1'b0, 1'b0, '0, 1'b1);
      n_vec++;
      if (o_pc !== AW'((k-6)*4) || o_valid !== 1'b1) begin
        n_err++; $display("FAIL rm_pc k=%0d got %h/v%b exp %h/v1", k, o_pc, o_valid, AW'((k-6)*4));
      end
    end
  endtask

  task automatic test_random();
    logic          j, rdy, have_last;
    logic [AW-1:0] ja, last_pc;
    have_last = 1'b0;
    last_pc   = '0;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      j   = ($urandom_range(0, 39) == 0);
      ja  = AW'($urandom_range(0, 200) * 4);
      rdy = 1'($urandom_range(0, 1));
      drive_cycle(1'b0, j, ja, rdy);
      n_vec++;
      if (sb.size() > DEPTH) begin n_err++; $display("FAIL rnd_outstanding k=%0d got %0d exp <=%0d", k, sb.size(), DEPTH); end
      if (j) begin
        n_vec++;
        if (o_valid !== 1'b0) begin n_err++; $display("FAIL rnd_jump_valid k=%0d got %b exp 0", k, o_valid); end
      end
      if (popped) begin
        n_vec++;
        if (!have_exp) begin n_err++; $display("FAIL rnd_sb_extra k=%0d got pc %h exp none", k, o_pc); end
        else if (o_pc !== exp_pc || o_inst !== (TAG | IW'(exp_pc))) begin
          n_err++; $display("FAIL rnd_sb k=%0d got %h/%h exp %h/%h", k, o_pc, o_inst, exp_pc, TAG | IW'(exp_pc));
        end
        if (have_last) begin
          n_vec++;
          if (o_pc !== last_pc + AW'(4)) begin n_err++; $display("FAIL rnd_contig k=%0d got %h exp %h", k, o_pc, last_pc + AW'(4)); end
        end
        last_pc   = o_pc;
        have_last = 1'b1;
      end
      if (j) have_last = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_jump_flush();
    test_jump_pop();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
